// File: rtl/imm_gen_queue.sv
// Immediate generator feeding a DEPTH-entry in-order result queue.
// Each accepted instruction yields one XLEN immediate plus its tag.
module imm_gen_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int TAG_W = 6
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instr,
   input  logic [2:0]             in_sel,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_imm,
   output logic [TAG_W-1:0]       out_tag,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      FMT_I     = 3'd0,
      FMT_S     = 3'd1,
      FMT_B     = 3'd2,
      FMT_U     = 3'd3,
      FMT_J     = 3'd4,
      FMT_Z     = 3'd5,
      FMT_VS5   = 3'd6,
      FMT_VTYPE = 3'd7
   } fmt_e;

   logic [XLEN-1:0]  imm_mem_q [DEPTH];
   logic [XLEN-1:0]  imm_mem_d [DEPTH];
   logic [TAG_W-1:0] tag_mem_q [DEPTH];
   logic [TAG_W-1:0] tag_mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [XLEN-1:0]  imm_new;
   logic             push;
   logic             pop;

   // Sign extension comes from the signed cast widening each field to XLEN.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      imm_new = '0;
      case (fmt_e'(in_sel))
         FMT_I:     imm_new = XLEN'($signed(in_instr[31:20]));
         FMT_S:     imm_new = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
         FMT_B:     imm_new = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                              in_instr[11:8], 1'b0}));
         FMT_U:     imm_new = XLEN'($signed({in_instr[31:12], 12'b0}));
         FMT_J:     imm_new = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                              in_instr[30:21], 1'b0}));
         FMT_Z:     imm_new = XLEN'(in_instr[19:15]);
         FMT_VS5:   imm_new = XLEN'($signed(in_instr[19:15]));
         FMT_VTYPE: imm_new = (in_instr[31:30] == 2'b11) ? XLEN'(in_instr[29:20])
                                                           : XLEN'(in_instr[30:20]);
         default:   imm_new = '0;
      endcase
   end

   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      imm_mem_d = imm_mem_q;
      tag_mem_d = tag_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      // Flush overrides both handshakes; any push this cycle is dropped.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            imm_mem_d[wr_ptr_q] = imm_new;
            tag_mem_d[wr_ptr_q] = in_tag;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: storage is cleared on reset because the head outputs must read 0 afterwards.
         for (int i = 0; i < DEPTH; i++) begin
            imm_mem_q[i] <= '0;
            tag_mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
         imm_mem_q <= imm_mem_d;
         tag_mem_q <= tag_mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   assign out_imm = imm_mem_q[rd_ptr_q];
   assign out_tag = tag_mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: tb/tb_imm_gen_queue.sv
// Randomised scoreboard bench for imm_gen_queue with directed corner cases,
// plus a second XLEN=64 instance for wide sign extension.
module tb_imm_gen_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int TAG_W = 6;

   logic              clock = 1'b0;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [2:0]        in_sel;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_imm;
   logic [TAG_W-1:0]  out_tag;
   logic [$clog2(DEPTH):0] count;

   logic              w_flush;
   logic              w_in_valid;
   logic              w_in_ready;
   logic [31:0]       w_in_instr;
   logic [2:0]        w_in_sel;
   logic [TAG_W-1:0]  w_in_tag;
   logic              w_out_valid;
   logic              w_out_ready;
   logic [63:0]       w_out_imm;
   logic [TAG_W-1:0]  w_out_tag;
   logic [$clog2(DEPTH):0] w_count;

   always #5 clock = ~clock;

   imm_gen_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_sel(in_sel), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_tag(out_tag), .count(count)
   );

   imm_gen_queue #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut64 (
      .clock(clock), .reset(reset), .flush(w_flush),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr),
      .in_sel(w_in_sel), .in_tag(w_in_tag),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_imm(w_out_imm),
      .out_tag(w_out_tag), .count(w_count)
   );

   typedef struct {
      logic [63:0]      imm;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;
   bit   last_acc = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Field value taken as an unsigned number; signed formats subtract 2^width
   // when their top bit is set, then the result is truncated to the data width.
   function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel,
                                           input int xlen);
      logic [63:0] f;
      int          w;
      bit          sgn;
      sgn = 1'b1;
      w   = 12;
      f   = '0;
      case (sel)
         3'd0: begin f = ins[31:20]; w = 12; end
         3'd1: begin f = {ins[31:25], ins[11:7]}; w = 12; end
         3'd2: begin f = {ins[31], ins[7], ins[30:25], ins[11:8]} * 2; w = 13; end
         3'd3: begin f = ins[31:12] * 4096; w = 32; end
         3'd4: begin f = {ins[31], ins[19:12], ins[20], ins[30:21]} * 2; w = 21; end
         3'd5: begin f = ins[19:15]; sgn = 1'b0; end
         3'd6: begin f = ins[19:15]; w = 5; end
         default: begin
            if (ins[31:30] == 2'b11) f = ins[29:20];
            else                     f = ins[30:20];
            sgn = 1'b0;
         end
      endcase
      if (sgn && f[w-1]) f = f - (64'd1 << w);
      if (xlen == 32) f = f & 64'h0000_0000_FFFF_FFFF;
      return f;
   endfunction

   // Monitor: model state mirrors DUT state between edges; pops on each handshake.
   always @(negedge clock) begin
      if (mon_en && !reset) begin
         check("count", 64'(count), 64'(exp_q.size()));
         check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         check("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
         if (out_valid && out_ready && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("out_imm", 64'(out_imm), mon_e.imm);
            check("out_tag", 64'(out_tag), 64'(mon_e.tag));
         end
      end
   end

   // One clock cycle: decide acceptance before the edge, update the model at it.
   task automatic step();
      exp_t e;
      bit   kill;
      bit   acc;
      @(negedge clock);
      kill  = flush || reset;
      acc   = in_valid && in_ready;
      e.imm = ref_imm(in_instr, in_sel, XLEN);
      e.tag = in_tag;
      @(posedge clock);
      if (kill)     exp_q.delete();
      else if (acc) exp_q.push_back(e);
      last_acc = acc && !kill;
      #1;
   endtask

   task automatic push_one(input logic [31:0] ins, input logic [2:0] sel,
                           input logic [TAG_W-1:0] tag);
      in_valid = 1'b1;
      in_instr = ins;
      in_sel   = sel;
      in_tag   = tag;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      check("drain_budget", 64'(exp_q.size()), 64'd0);
      out_ready = 1'b0;
   endtask

   logic [31:0] v_ins [7] = '{32'hFFF00093, 32'h80000063, 32'h800000EF, 32'h800000B7,
                              32'h000F8057, 32'h000F8057, 32'hCD0F8057};
   logic [2:0]  v_sel [7] = '{3'd0, 3'd2, 3'd4, 3'd3, 3'd6, 3'd5, 3'd7};
   logic [31:0] v_exp [7] = '{32'hFFFFFFFF, 32'hFFFFF000, 32'hFFF00000, 32'h80000000,
                              32'hFFFFFFFF, 32'h0000001F, 32'h000000D0};

   initial begin
      reset      = 1'b1;
      flush      = 1'b0;
      in_valid   = 1'b0;
      in_instr   = '0;
      in_sel     = '0;
      in_tag     = '0;
      out_ready  = 1'b0;
      w_flush    = 1'b0;
      w_in_valid = 1'b0;
      w_in_instr = '0;
      w_in_sel   = '0;
      w_in_tag   = '0;
      w_out_ready = 1'b1;
      repeat (2) step();
      reset  = 1'b0;
      mon_en = 1'b1;

      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_imm", 64'(out_imm), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Known-answer vectors, each into an empty queue with latency one.
      for (int i = 0; i < 7; i++) begin
         push_one(v_ins[i], v_sel[i], TAG_W'(i + 1));
         check($sformatf("kat%0d_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("kat%0d_imm", i), 64'(out_imm), 64'(v_exp[i]));
         check($sformatf("kat%0d_count", i), 64'(count), 64'd1);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end

      // Wide instance: directed U-type plus random formats against the model.
      w_in_valid = 1'b1;
      w_in_instr = 32'h800000B7;
      w_in_sel   = 3'd3;
      w_in_tag   = 6'd9;
      step();
      w_in_valid = 1'b0;
      check("x64_valid", 64'(w_out_valid), 64'd1);
      check("x64_u_imm", w_out_imm, 64'hFFFFFFFF80000000);
      check("x64_tag", 64'(w_out_tag), 64'd9);
      step();
      for (int i = 0; i < 24; i++) begin
         w_in_valid = 1'b1;
         w_in_instr = $urandom;
         w_in_sel   = 3'($urandom_range(0, 7));
         w_in_tag   = TAG_W'($urandom);
         step();
         w_in_valid = 1'b0;
         check("x64_rand_imm", w_out_imm, ref_imm(w_in_instr, w_in_sel, 64));
         check("x64_rand_tag", 64'(w_out_tag), 64'(w_in_tag));
         step();
      end

      // Fill to full with the consumer stalled, then release across pointer wrap.
      for (int t = 0; t < 4; t++) push_one($urandom, 3'($urandom_range(0, 7)), TAG_W'(t));
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      in_instr = $urandom;
      in_sel   = 3'($urandom_range(0, 7));
      in_tag   = TAG_W'(4);
      repeat (3) step();
      check("full_hold_count", 64'(count), 64'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (last_acc) break;
      end
      check("full_tag4_accepted", 64'(last_acc), 64'd1);
      drain();

      // Steady occupancy of two with simultaneous push and pop.
      for (int t = 0; t < 2; t++) push_one($urandom, 3'($urandom_range(0, 7)), TAG_W'(10 + t));
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_instr = $urandom;
         in_sel   = 3'($urandom_range(0, 7));
         in_tag   = TAG_W'(20 + i);
         step();
         check("pp_count", 64'(count), 64'd2);
      end
      drain();

      // Flush with a concurrent push, then a mid-stream reset.
      for (int t = 0; t < 3; t++) push_one($urandom, 3'($urandom_range(0, 7)), TAG_W'(30 + t));
      flush    = 1'b1;
      in_valid = 1'b1;
      in_tag   = TAG_W'(33);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_count", 64'(count), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      step();
      check("flush_dropped", 64'(count), 64'd0);
      for (int t = 0; t < 2; t++) push_one(32'hFFF00093, 3'd0, TAG_W'(40 + t));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst2_count", 64'(count), 64'd0);
      check("rst2_out_valid", 64'(out_valid), 64'd0);
      check("rst2_out_imm", 64'(out_imm), 64'd0);
      check("rst2_out_tag", 64'(out_tag), 64'd0);

      // Random traffic with occasional flushes; inputs held while stalled.
      for (int i = 0; i < 1500; i++) begin
         if (!(in_valid && !last_acc)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = $urandom;
            in_sel   = 3'($urandom_range(0, 7));
            in_tag   = TAG_W'($urandom);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 63) == 0);
         step();
      end
      flush = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
